gearbox_n2w: RTL and testbench

- Parametrised narrow-to-wide gearbox for the PHY receive path. Successor to the fixed 8->32 packer.
- Packs IN_W-bit symbols into words of 1, 2 or RATIO_MAX symbols, selected at run time by PCLK.
- Adds a valid handshake on both sides, an explicit flush of partial words, and a beat-count output.
- Sits between the deserialiser/decoder and the lane/PIPE interface logic.

---
 rtl/phy_gearbox_pkg.sv | 19 +
 rtl/gearbox_lane_wr.sv | 25 ++
 rtl/gearbox_n2w.sv | 107 ++++++++++
 tb/tb_gearbox_n2w.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_gearbox_pkg.sv
// Shared definitions for the PHY gearbox family: width-mode encodings and the
// mode-to-ratio mapping used by both packing directions.
package phy_gearbox_pkg;

  localparam logic [1:0] MODE_X4   = 2'b00;
  localparam logic [1:0] MODE_X2   = 2'b01;
  localparam logic [1:0] MODE_X1   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // Reserved encoding falls through to the full ratio.
  function automatic int unsigned ratio_of(input logic [1:0] mode, input int unsigned ratio_max);
    case (mode)
      MODE_X2: return ratio_max >> 1;
      MODE_X1: return ratio_max >> 2;
      default: return ratio_max;
    endcase
  endfunction

endpackage

// File: rtl/gearbox_lane_wr.sv
// Combinational merge of one symbol into a right-aligned word at beat position
// pos, MSB-first: beat 0 lands in the highest occupied slot.
module gearbox_lane_wr #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned RATIO_MAX = 4,
  parameter int unsigned OUT_W     = IN_W * RATIO_MAX,
  parameter int unsigned CW        = $clog2(RATIO_MAX) + 1
) (
  input  logic [OUT_W-1:0] base,
  input  logic [IN_W-1:0]  sym,
  input  logic [CW-1:0]    pos,
  input  logic [CW-1:0]    ratio,
  output logic [OUT_W-1:0] merged
);

  always_comb begin
    merged = base;
    for (int j = 0; j < int'(RATIO_MAX); j++) begin
      if (j == int'(ratio) - 1 - int'(pos)) begin
        merged[j*IN_W +: IN_W] = sym;
      end
    end
  end

endmodule

// File: rtl/gearbox_n2w.sv
// Narrow-to-wide receive gearbox: packs IN_W symbols into 1, 2 or RATIO_MAX
// symbol words with flush of partial words and a per-word beat count.
module gearbox_n2w
  import phy_gearbox_pkg::*;
#(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned RATIO_MAX = 4,
  parameter int unsigned OUT_W     = IN_W * RATIO_MAX,
  parameter int unsigned CW        = $clog2(RATIO_MAX) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENB,
  input  logic [1:0]       PCLK,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  input  logic             flush,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [CW-1:0]    out_cnt
);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] shadow_q, shadow_d;
  logic [1:0]       mode_q, mode_d;
  logic [OUT_W-1:0] out_d;
  logic             out_valid_d;
  logic [CW-1:0]    out_cnt_d;

  logic [1:0]       mode_n;
  logic [CW-1:0]    ratio;
  logic             discard;
  logic [CW-1:0]    base_cnt;
  logic [OUT_W-1:0] base_shadow;
  logic [OUT_W-1:0] merged;
  logic [CW-1:0]    next_cnt;
  logic             emit;

  assign mode_n = (PCLK == MODE_RSVD) ? MODE_X4 : PCLK;
  assign ratio  = CW'(ratio_of(mode_n, RATIO_MAX));

  // A mode switch abandons any partial word; this edge's beat starts afresh.
  assign discard     = (mode_n != mode_q) && (cnt_q != '0);
  assign base_cnt    = discard ? '0 : cnt_q;
  assign base_shadow = discard ? '0 : shadow_q;
  assign next_cnt    = base_cnt + CW'(in_valid);
  assign emit        = (in_valid && (next_cnt == ratio)) || (flush && (next_cnt != '0));

  gearbox_lane_wr #(
    .IN_W      (IN_W),
    .RATIO_MAX (RATIO_MAX),
    .OUT_W     (OUT_W),
    .CW        (CW)
  ) u_lane_wr (
    .base   (base_shadow),
    .sym    (in),
    .pos    (base_cnt),
    .ratio  (ratio),
    .merged (merged)
  );

  always_comb begin
    cnt_d       = cnt_q;
    shadow_d    = shadow_q;
    mode_d      = mode_q;
    out_d       = out;
    out_cnt_d   = out_cnt;
    out_valid_d = 1'b0;
    if (!ENB) begin
      cnt_d     = '0;
      shadow_d  = '0;
      mode_d    = MODE_X4;
      out_d     = '0;
      out_cnt_d = '0;
    end else begin
      mode_d   = mode_n;
      cnt_d    = next_cnt;
      shadow_d = in_valid ? merged : base_shadow;
      if (emit) begin
        out_d       = in_valid ? merged : base_shadow;
        out_cnt_d   = next_cnt;
        out_valid_d = 1'b1;
        cnt_d       = '0;
        shadow_d    = '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      shadow_q  <= '0;
      mode_q    <= MODE_X4;
      out       <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      mode_q    <= mode_d;
      out       <= out_d;
      out_cnt   <= out_cnt_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_gearbox_n2w.sv
// Self-checking bench for gearbox_n2w: directed scenarios plus a randomized run
// against a queue-based packing model.
module tb_gearbox_n2w;

  localparam int unsigned IN_W      = 8;
  localparam int unsigned RATIO_MAX = 4;
  localparam int unsigned OUT_W     = IN_W * RATIO_MAX;
  localparam int unsigned CW        = $clog2(RATIO_MAX) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             enb;
  logic [1:0]       pclk;
  logic             in_valid;
  logic [IN_W-1:0]  in_sym;
  logic             flush;
  logic [OUT_W-1:0] out;
  logic             out_valid;
  logic [CW-1:0]    out_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Words observed leaving the DUT, for the directed scenarios.
  logic [OUT_W-1:0] got_word[$];
  logic [CW-1:0]    got_cnt[$];
  int               got_cyc[$];

  // Reference model state.
  logic [IN_W-1:0]  mdl_buf[$];
  logic [1:0]       mdl_mode;
  logic             exp_valid;
  logic [OUT_W-1:0] exp_out;
  logic [CW-1:0]    exp_cnt;

  gearbox_n2w #(
    .IN_W      (IN_W),
    .RATIO_MAX (RATIO_MAX)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .ENB       (enb),
    .PCLK      (pclk),
    .in_valid  (in_valid),
    .in        (in_sym),
    .flush     (flush),
    .out       (out),
    .out_valid (out_valid),
    .out_cnt   (out_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    mdl_buf.delete();
    mdl_mode  = 2'b00;
    exp_valid = 1'b0;
    exp_out   = '0;
    exp_cnt   = '0;
  endtask

  task automatic model_edge(input logic e, input logic [1:0] pc, input logic v,
                            input logic [IN_W-1:0] d, input logic fl);
    logic [1:0] m;
    int         r;
    int         n;
    logic [OUT_W-1:0] w;
    if (!e) begin
      model_clear();
      return;
    end
    m = (pc == 2'b11) ? 2'b00 : pc;
    if (m != mdl_mode && mdl_buf.size() > 0) mdl_buf.delete();
    mdl_mode  = m;
    r         = RATIO_MAX >> m;
    exp_valid = 1'b0;
    if (v) mdl_buf.push_back(d);
    n = mdl_buf.size();
    if (n == r || (fl && n > 0)) begin
      w = '0;
      foreach (mdl_buf[i]) w = (w << IN_W) | OUT_W'(mdl_buf[i]);
      w         = w << ((r - n) * IN_W);
      exp_out   = w;
      exp_cnt   = CW'(n);
      exp_valid = 1'b1;
      mdl_buf.delete();
    end
  endtask

  // Drive one cycle of inputs, clock it, sample #1 after the edge.
  task automatic step(input logic e, input logic [1:0] pc, input logic v,
                      input logic [IN_W-1:0] d, input logic fl);
    enb = e; pclk = pc; in_valid = v; in_sym = d; flush = fl;
    @(posedge clk);
    model_edge(e, pc, v, d, fl);
    #1;
    cyc++;
    if (out_valid) begin
      got_word.push_back(out);
      got_cnt.push_back(out_cnt);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic clear_got();
    got_word.delete();
    got_cnt.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    step(1, 2'b00, 1, 8'h01, 0);
    step(1, 2'b00, 1, 8'h02, 0);
    step(1, 2'b00, 1, 8'h03, 0);
    step(1, 2'b00, 1, 8'h04, 0);
    step(1, 2'b00, 1, 8'hA1, 0);
    step(1, 2'b00, 1, 8'hB2, 0);
    rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (out !== '0) begin
      errors++; $display("FAIL reset_out: got %h want 0", out);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    checks++;
    if (out_cnt !== '0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", out_cnt);
    end
    #1 rst = 1'b0;
    clear_got();
    step(1, 2'b00, 1, 8'hC3, 0);
    step(1, 2'b00, 1, 8'hD4, 0);
    step(1, 2'b00, 1, 8'hE5, 0);
    step(1, 2'b00, 1, 8'hF6, 0);
    step(1, 2'b00, 0, 8'h00, 0);
    checks++;
    if (got_word.size() != 1 || got_word[0] !== 32'hC3D4E5F6 || got_cnt[0] !== 3'd4) begin
      errors++;
      $display("FAIL reset_resume: got %0d words first %h/%0d want 1 word c3d4e5f6/4",
               got_word.size(), got_word.size() ? got_word[0] : '0,
               got_cnt.size() ? got_cnt[0] : '0);
    end
  endtask

  task automatic test_full_x4();
    logic [IN_W-1:0] b;
    clear_got();
    for (int i = 0; i < 8; i++) begin
      b = IN_W'(8'h11 * (i + 1));
      step(1, 2'b00, 1, b, 0);
    end
    step(1, 2'b00, 0, 8'h00, 0);
    checks++;
    if (got_word.size() != 2) begin
      errors++; $display("FAIL x4_count: got %0d words want 2", got_word.size());
    end else begin
      checks++;
      if (got_word[0] !== 32'h11223344 || got_cnt[0] !== 3'd4) begin
        errors++; $display("FAIL x4_word0: got %h/%0d want 11223344/4", got_word[0], got_cnt[0]);
      end
      checks++;
      if (got_word[1] !== 32'h55667788 || got_cnt[1] !== 3'd4) begin
        errors++; $display("FAIL x4_word1: got %h/%0d want 55667788/4", got_word[1], got_cnt[1]);
      end
      checks++;
      if (got_cyc[1] - got_cyc[0] != 4) begin
        errors++; $display("FAIL x4_spacing: got %0d cycles want 4", got_cyc[1] - got_cyc[0]);
      end
    end
  endtask

  task automatic test_modes();
    clear_got();
    step(1, 2'b01, 1, 8'hAB, 0);
    step(1, 2'b01, 1, 8'hCD, 0);
    checks++;
    if (got_word.size() != 1 || got_word[0] !== 32'h0000ABCD || got_cnt[0] !== 3'd2) begin
      errors++; $display("FAIL x2_word: got %0d words first %h want 1 word 0000abcd/2",
                         got_word.size(), got_word.size() ? got_word[0] : '0);
    end
    clear_got();
    step(1, 2'b10, 1, 8'h5A, 0);
    step(1, 2'b10, 1, 8'h5B, 0);
    step(1, 2'b10, 1, 8'h5C, 0);
    checks++;
    if (got_word.size() != 3) begin
      errors++; $display("FAIL x1_count: got %0d words want 3", got_word.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_word[i] !== OUT_W'(8'h5A + i) || got_cnt[i] !== 3'd1) begin
          errors++; $display("FAIL x1_word%0d: got %h/%0d want %h/1", i, got_word[i],
                             got_cnt[i], OUT_W'(8'h5A + i));
        end
      end
    end
  endtask

  task automatic test_flush();
    clear_got();
    step(1, 2'b00, 1, 8'h12, 0);
    step(1, 2'b00, 1, 8'h34, 0);
    step(1, 2'b00, 0, 8'h00, 1);
    step(1, 2'b00, 0, 8'h00, 1);
    step(1, 2'b00, 0, 8'h00, 0);
    checks++;
    if (got_word.size() != 1 || got_word[0] !== 32'h12340000 || got_cnt[0] !== 3'd2) begin
      errors++; $display("FAIL flush_partial: got %0d words first %h want 1 word 12340000/2",
                         got_word.size(), got_word.size() ? got_word[0] : '0);
    end
    checks++;
    if (out !== 32'h12340000) begin
      errors++; $display("FAIL flush_hold: got %h want 12340000", out);
    end
    clear_got();
    step(1, 2'b00, 1, 8'hE1, 0);
    step(1, 2'b00, 1, 8'hE2, 0);
    step(1, 2'b00, 1, 8'hE3, 0);
    step(1, 2'b00, 1, 8'hE4, 1);
    step(1, 2'b00, 0, 8'h00, 1);
    checks++;
    if (got_word.size() != 1 || got_word[0] !== 32'hE1E2E3E4 || got_cnt[0] !== 3'd4) begin
      errors++; $display("FAIL flush_full: got %0d words first %h want 1 word e1e2e3e4/4",
                         got_word.size(), got_word.size() ? got_word[0] : '0);
    end
  endtask

  task automatic test_mode_change();
    clear_got();
    step(1, 2'b00, 1, 8'h01, 0);
    step(1, 2'b00, 1, 8'h02, 0);
    step(1, 2'b01, 1, 8'h03, 0);
    step(1, 2'b01, 1, 8'h04, 0);
    step(1, 2'b01, 0, 8'h00, 0);
    checks++;
    if (got_word.size() != 1 || got_word[0] !== 32'h00000304 || got_cnt[0] !== 3'd2) begin
      errors++; $display("FAIL mode_change: got %0d words first %h want 1 word 00000304/2",
                         got_word.size(), got_word.size() ? got_word[0] : '0);
    end
  endtask

  task automatic test_enb_drop();
    clear_got();
    step(1, 2'b00, 1, 8'h9A, 0);
    step(1, 2'b00, 0, 8'h00, 0);
    step(1, 2'b00, 1, 8'h9B, 0);
    step(0, 2'b00, 1, 8'h77, 1);
    checks++;
    if (out !== '0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL enb_clear: got %h/%b want 0/0", out, out_valid);
    end
    for (int i = 0; i < 4; i++) step(1, 2'b00, 1, IN_W'(8'hC0 + i), 0);
    step(1, 2'b00, 0, 8'h00, 0);
    checks++;
    if (got_word.size() != 1 || got_word[0] !== 32'hC0C1C2C3 || got_cnt[0] !== 3'd4) begin
      errors++; $display("FAIL enb_resume: got %0d words first %h want 1 word c0c1c2c3/4",
                         got_word.size(), got_word.size() ? got_word[0] : '0);
    end
  endtask

  task automatic test_random();
    logic             e, v, fl;
    logic [1:0]       pc;
    logic [IN_W-1:0]  d;
    pc = 2'b00;
    for (int i = 0; i < 600; i++) begin
      e  = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 15) == 0) pc = 2'($urandom_range(0, 3));
      v  = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 9) == 0);
      d  = IN_W'($urandom);
      step(e, pc, v, d, fl);
      checks++;
      if (out_valid !== exp_valid) begin
        errors++; $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, exp_valid);
      end
      checks++;
      if (out !== exp_out || out_cnt !== exp_cnt) begin
        errors++; $display("FAIL rand_word[%0d]: got %h/%0d want %h/%0d", i, out, out_cnt,
                           exp_out, exp_cnt);
      end
    end
  endtask

  initial begin
    rst = 1'b1; enb = 1'b0; pclk = 2'b00; in_valid = 1'b0; in_sym = '0; flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_full_x4();
    test_modes();
    test_flush();
    test_mode_change();
    test_enb_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
